// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of an external pin and
// serves coherent period/high-time pairs and status over the SPI command bus.
module pwm_capture #(
    parameter logic [7:0]  DEV_ID                = 8'd0,
    parameter int          CNTR_WIDTH            = 16,
    parameter logic [15:0] C_SET_PWM_CAP_TIMEOUT = 16'h0050,
    parameter logic [15:0] C_GET_PWM_CAP_PERIOD  = 16'h0051,
    parameter logic [15:0] C_GET_PWM_CAP_HIGH    = 16'h0052,
    parameter logic [15:0] C_GET_PWM_CAP_STATUS  = 16'h0053
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    input  logic [15:0] spi_cmd_r,
    input  logic [7:0]  spi_addr_r,
    input  logic [39:0] spi_data_r,
    input  logic        spi_data_valid_r,
    output logic [39:0] rd_data,
    output logic        rd_valid,
    output logic        meas_valid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONES = '1;
    localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
    localparam int                    PAD_W    = 40 - CNTR_WIDTH;

    logic                  sync1_q, sync2_q, sdly_q;
    logic [1:0]            state_q, state_d;
    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0] high_tmp_q, high_tmp_d;
    logic [CNTR_WIDTH-1:0] period_q, period_d;
    logic [CNTR_WIDTH-1:0] high_q, high_d;
    logic [CNTR_WIDTH-1:0] shadow_q, shadow_d;
    logic [CNTR_WIDTH-1:0] timeout_q, timeout_d;
    logic                  meas_valid_q, meas_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  to_flag_q, to_flag_d;
    logic                  stuck_q, stuck_d;
    logic [39:0]           rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic rise_s, fall_s, hit_s, timeout_s, commit_s;
    // upper write-data bits are not used by this block
    logic unused_data_s;

    assign unused_data_s = ^spi_data_r[39:CNTR_WIDTH];
    assign rise_s    = sync2_q & ~sdly_q;
    assign fall_s    = ~sync2_q & sdly_q;
    assign hit_s     = spi_data_valid_r && (spi_addr_r == DEV_ID);
    assign timeout_s = ((timeout_q != CNT_ZERO) && (cnt_q == timeout_q)) || (cnt_q == CNT_ONES);
    assign commit_s  = (state_q == ST_LOW) && rise_s;

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign meas_valid = meas_valid_q;

    // Next-state logic: measurement FSM, counter and SPI command decode.
    always_comb begin
        state_d      = state_q;
        high_tmp_d   = high_tmp_q;
        period_d     = period_q;
        high_d       = high_q;
        shadow_d     = shadow_q;
        timeout_d    = timeout_q;
        meas_valid_d = meas_valid_q;
        overrun_d    = overrun_q;
        to_flag_d    = to_flag_q;
        stuck_d      = stuck_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;

        if (rise_s) begin
            cnt_d = CNT_ONE;
        end else if (state_q != ST_IDLE) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        // Edges win over a timeout landing on the same cycle.
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH, ST_LOW: begin
                if ((state_q == ST_HIGH) && fall_s) begin
                    high_tmp_d = cnt_q;
                    state_d    = ST_LOW;
                end else if (commit_s) begin
                    period_d     = cnt_q;
                    high_d       = high_tmp_q;
                    meas_valid_d = 1'b1;
                    overrun_d    = 1'b1;
                    to_flag_d    = 1'b0;
                    state_d      = ST_HIGH;
                end else if (timeout_s) begin
                    period_d     = CNT_ZERO;
                    high_d       = CNT_ZERO;
                    meas_valid_d = 1'b0;
                    to_flag_d    = 1'b1;
                    stuck_d      = sync2_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reads sample pre-commit values; a coincident commit keeps overrun set.
        if (hit_s) begin
            case (spi_cmd_r)
                C_SET_PWM_CAP_TIMEOUT: timeout_d = spi_data_r[CNTR_WIDTH-1:0];
                C_GET_PWM_CAP_PERIOD: begin
                    rd_data_d  = {{PAD_W{1'b0}}, period_q};
                    rd_valid_d = 1'b1;
                    shadow_d   = high_q;
                    overrun_d  = commit_s;
                end
                C_GET_PWM_CAP_HIGH: begin
                    rd_data_d  = {{PAD_W{1'b0}}, shadow_q};
                    rd_valid_d = 1'b1;
                end
                C_GET_PWM_CAP_STATUS: begin
                    rd_data_d  = {36'd0, to_flag_q, overrun_q, stuck_q, meas_valid_q};
                    rd_valid_d = 1'b1;
                end
                default: rd_valid_d = 1'b0;
            endcase
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sdly_q       <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            high_tmp_q   <= CNT_ZERO;
            period_q     <= CNT_ZERO;
            high_q       <= CNT_ZERO;
            shadow_q     <= CNT_ZERO;
            timeout_q    <= CNT_ONES;
            meas_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            to_flag_q    <= 1'b0;
            stuck_q      <= 1'b0;
            rd_data_q    <= 40'd0;
            rd_valid_q   <= 1'b0;
        end else begin
            sync1_q      <= pwm_in;
            sync2_q      <= sync1_q;
            sdly_q       <= sync2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            high_tmp_q   <= high_tmp_d;
            period_q     <= period_d;
            high_q       <= high_d;
            shadow_q     <= shadow_d;
            timeout_q    <= timeout_d;
            meas_valid_q <= meas_valid_d;
            overrun_q    <= overrun_d;
            to_flag_q    <= to_flag_d;
            stuck_q      <= stuck_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: read responses are scored against a
// queue of expected values pushed when each GET is issued.
module tb_pwm_capture;

    localparam logic [7:0]  DEV      = 8'h05;
    localparam logic [15:0] C_SET    = 16'h0050;
    localparam logic [15:0] C_PERIOD = 16'h0051;
    localparam logic [15:0] C_HIGH   = 16'h0052;
    localparam logic [15:0] C_STATUS = 16'h0053;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [15:0] spi_cmd_r;
    logic [7:0]  spi_addr_r;
    logic [39:0] spi_data_r;
    logic        spi_data_valid_r;
    logic [39:0] rd_data;
    logic        rd_valid;
    logic        meas_valid;

    typedef struct {
        string       name;
        logic [39:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pwm_capture #(
        .DEV_ID               (DEV),
        .CNTR_WIDTH           (16),
        .C_SET_PWM_CAP_TIMEOUT(C_SET),
        .C_GET_PWM_CAP_PERIOD (C_PERIOD),
        .C_GET_PWM_CAP_HIGH   (C_HIGH),
        .C_GET_PWM_CAP_STATUS (C_STATUS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pwm_in          (pwm_in),
        .spi_cmd_r       (spi_cmd_r),
        .spi_addr_r      (spi_addr_r),
        .spi_data_r      (spi_data_r),
        .spi_data_valid_r(spi_data_valid_r),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .meas_valid      (meas_valid)
    );

    // Scoreboard: every rd_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_rd_valid: got rd_data=0x%0h, required no response", rd_data);
            end else begin
                e = sb_q.pop_front();
                if (rd_data !== e.val)
                    $display("FAIL %s: got 0x%0h, required 0x%0h", e.name, rd_data, e.val);
                else
                    n_pass++;
            end
        end
    end

    task automatic spi(input logic [15:0] cmd, input logic [7:0] addr, input logic [39:0] data);
        spi_cmd_r        = cmd;
        spi_addr_r       = addr;
        spi_data_r       = data;
        spi_data_valid_r = 1'b1;
        @(negedge clk);
        spi_data_valid_r = 1'b0;
        spi_cmd_r        = 16'h0000;
        spi_data_r       = 40'd0;
    endtask

    task automatic get(input logic [15:0] cmd, input logic [39:0] expv, input string name);
        exp_t e;
        e.name = name;
        e.val  = expv;
        sb_q.push_back(e);
        spi(cmd, DEV, 40'd0);
    endtask

    task automatic pwm_level(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_cycles(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_level(1'b1, hi);
            pwm_level(1'b0, lo);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_valid, rd_data, meas_valid} !== 42'd0)
            $display("FAIL reset_outputs: got valid=%b data=0x%0h meas=%b, required 0/0/0", rd_valid, rd_data, meas_valid);
        else
            n_pass++;
        reset = 1'b0;
        @(negedge clk);
        get(C_STATUS, 40'h0, "reset_status");
        get(C_PERIOD, 40'd0, "reset_period");
        get(C_HIGH, 40'd0, "reset_high");
        @(negedge clk);
    endtask

    task automatic test_basic;
        pwm_cycles(25, 75, 4);
        pwm_level(1'b1, 5);
        n_checks++;
        if (meas_valid !== 1'b1)
            $display("FAIL basic_meas_valid: got %b, required 1", meas_valid);
        else
            n_pass++;
        get(C_PERIOD, 40'd100, "basic_period");
        get(C_HIGH, 40'd25, "basic_high");
        get(C_STATUS, 40'h1, "basic_status");
    endtask

    task automatic test_coherent;
        pwm_cycles(60, 40, 3);
        pwm_level(1'b1, 5);
        get(C_HIGH, 40'd25, "coherent_shadow_high");
        get(C_STATUS, 40'h5, "coherent_status_overrun");
        get(C_PERIOD, 40'd100, "coherent_new_period");
        get(C_HIGH, 40'd60, "coherent_new_high");
        pwm_level(1'b0, 40);
    endtask

    task automatic test_timeout;
        spi(C_SET, DEV, 40'd500);
        pwm_level(1'b1, 490);
        n_checks++;
        if (meas_valid !== 1'b1)
            $display("FAIL timeout_not_early: got meas_valid=%b, required 1", meas_valid);
        else
            n_pass++;
        pwm_level(1'b1, 20);
        n_checks++;
        if (meas_valid !== 1'b0)
            $display("FAIL timeout_meas_valid: got %b, required 0", meas_valid);
        else
            n_pass++;
        get(C_PERIOD, 40'd0, "timeout_period");
        get(C_HIGH, 40'd0, "timeout_high");
        get(C_STATUS, 40'hA, "timeout_status");
        pwm_level(1'b0, 10);
        pwm_cycles(10, 10, 3);
        pwm_level(1'b1, 5);
        get(C_PERIOD, 40'd20, "resume_period");
        get(C_HIGH, 40'd10, "resume_high");
        get(C_STATUS, 40'h3, "resume_status");
    endtask

    task automatic test_saturation;
        spi(C_SET, DEV, 40'd0);
        pwm_level(1'b0, 65000);
        n_checks++;
        if (meas_valid !== 1'b1)
            $display("FAIL sat_not_early: got meas_valid=%b, required 1", meas_valid);
        else
            n_pass++;
        pwm_level(1'b0, 600);
        n_checks++;
        if (meas_valid !== 1'b0)
            $display("FAIL sat_meas_valid: got %b, required 0", meas_valid);
        else
            n_pass++;
        get(C_PERIOD, 40'd0, "sat_period");
        get(C_STATUS, 40'h8, "sat_status");
    endtask

    task automatic test_back_to_back;
        // GET_PERIOD lands on the commit edge of the 12/18 period.
        pwm_cycles(10, 10, 3);
        pwm_level(1'b1, 12);
        pwm_level(1'b0, 18);
        pwm_level(1'b1, 2);
        get(C_PERIOD, 40'd20, "same_cycle_old_period");
        get(C_STATUS, 40'h5, "same_cycle_overrun");
        get(C_HIGH, 40'd10, "same_cycle_old_high");
        get(C_PERIOD, 40'd30, "same_cycle_new_period");
        get(C_HIGH, 40'd12, "same_cycle_new_high");
    endtask

    task automatic test_reset_mid;
        pwm_level(1'b1, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({rd_valid, rd_data, meas_valid} !== 42'd0)
            $display("FAIL midreset_outputs: got valid=%b data=0x%0h meas=%b, required 0/0/0", rd_valid, rd_data, meas_valid);
        else
            n_pass++;
        spi(C_PERIOD, DEV + 8'd1, 40'd0);
        n_checks++;
        if ({rd_valid, rd_data} !== 41'd0)
            $display("FAIL wrong_dev_get: got valid=%b data=0x%0h, required 0/0", rd_valid, rd_data);
        else
            n_pass++;
        spi(16'h00FF, DEV, 40'd0);
        n_checks++;
        if (rd_valid !== 1'b0)
            $display("FAIL unknown_cmd: got rd_valid=%b, required 0", rd_valid);
        else
            n_pass++;
        spi(C_SET, DEV + 8'd1, 40'd30);
        pwm_level(1'b1, 40);
        get(C_STATUS, 40'h0, "midreset_status");
        get(C_PERIOD, 40'd0, "midreset_period");
        get(C_HIGH, 40'd0, "midreset_high");
        @(negedge clk);
    endtask

    initial begin
        reset            = 1'b1;
        pwm_in           = 1'b0;
        spi_cmd_r        = 16'h0000;
        spi_addr_r       = 8'h00;
        spi_data_r       = 40'd0;
        spi_data_valid_r = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_coherent();
        test_timeout();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0)
            $display("FAIL missing_responses: got %0d unanswered reads, required 0", sb_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
